// File: rtl/ula_arbitro_if.sv
// ula_arbitro_if: request/response bus between two requesters and the shared ula arbiter
interface ula_arbitro_if;
  logic        req_valid0, req_ready0, req_valid1, req_ready1;
  logic [31:0] req_in1_0, req_in2_0, req_in1_1, req_in2_1;
  logic [3:0]  req_ctrl0, req_ctrl1;
  logic        resp_valid0, resp_valid1, resp_ready0, resp_ready1;
  logic [31:0] resp_result;
  logic        resp_zero, resp_err;
  modport master (
    output req_valid0, req_in1_0, req_in2_0, req_ctrl0, resp_ready0,
    output req_valid1, req_in1_1, req_in2_1, req_ctrl1, resp_ready1,
    input  req_ready0, req_ready1, resp_valid0, resp_valid1, resp_result, resp_zero, resp_err
  );
  modport slave (
    input  req_valid0, req_in1_0, req_in2_0, req_ctrl0, resp_ready0,
    input  req_valid1, req_in1_1, req_in2_1, req_ctrl1, resp_ready1,
    output req_ready0, req_ready1, resp_valid0, resp_valid1, resp_result, resp_zero, resp_err
  );
endinterface

// File: rtl/ula_arbitro.sv
// ula_arbitro: round-robin sharing of one registered 32-bit ula between two requesters
module ula_arbitro #(
  parameter bit PRIO_INICIAL = 1'b0
) (
  input logic         clk,
  input logic         reset,
  ula_arbitro_if.slave bus
);
  typedef enum logic [1:0] {OCIOSO, EXEC, RESP} state_t;
  state_t      r_state, w_next;
  logic        r_prio, r_owner, r_zero, r_err;
  logic [31:0] r_in1, r_in2, r_result, w_res;
  logic [3:0]  r_ctrl;
  logic        w_any, w_win, w_accept, w_ack, w_big, w_bad;
  assign w_any    = bus.req_valid0 | bus.req_valid1;
  assign w_win    = (bus.req_valid0 & bus.req_valid1) ? r_prio : bus.req_valid1;
  assign w_accept = (r_state == OCIOSO) & w_any;
  assign w_ack    = r_owner ? bus.resp_ready1 : bus.resp_ready0;
  // shift amounts of 32 or more flush the operand to zero
  assign w_big    = |r_in2[31:5];
  assign w_bad    = r_ctrl > 4'd8;
  always_comb begin
    w_res = '0;
    case (r_ctrl)
      4'd0: w_res = r_in1 & r_in2;
      4'd1: w_res = r_in1 | r_in2;
      4'd2: w_res = r_in1 + r_in2;
      4'd3: w_res = w_big ? '0 : r_in1 << r_in2[4:0];
      4'd4: w_res = r_in1 - r_in2;
      4'd5: w_res = w_big ? '0 : r_in1 >> r_in2[4:0];
      4'd6: w_res = r_in1 * r_in2;
      4'd7: w_res = r_in1 ^ r_in2;
      4'd8: w_res = {31'b0, r_in1 < r_in2};
      default: w_res = '0;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) r_state <= OCIOSO;
    else r_state <= w_next;
  always_comb
    w_next = (r_state == OCIOSO) ? (w_any ? EXEC : OCIOSO) :
             (r_state == EXEC)   ? RESP : (w_ack ? OCIOSO : RESP);
  always_comb begin
    bus.req_ready0  = w_accept & ~w_win;
    bus.req_ready1  = w_accept & w_win;
    bus.resp_valid0 = (r_state == RESP) & ~r_owner;
    bus.resp_valid1 = (r_state == RESP) & r_owner;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio   <= PRIO_INICIAL;
      r_owner  <= 1'b0;
      r_in1    <= '0;
      r_in2    <= '0;
      r_ctrl   <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_in1   <= w_win ? bus.req_in1_1 : bus.req_in1_0;
        r_in2   <= w_win ? bus.req_in2_1 : bus.req_in2_0;
        r_ctrl  <= w_win ? bus.req_ctrl1 : bus.req_ctrl0;
        r_owner <= w_win;
        r_prio  <= ~w_win;
      end
      if (r_state == EXEC) begin
        r_result <= w_res;
        r_zero   <= w_res == '0;
        r_err    <= w_bad;
      end
    end
  end
  assign bus.resp_result = r_result;
  assign bus.resp_zero   = r_zero;
  assign bus.resp_err    = r_err;
endmodule

// File: tb/tb_ula_arbitro.sv
// tb_ula_arbitro: directed and randomized checks of ula_arbitro against a behavioural model
module tb_ula_arbitro;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail = 0;
  logic mprio;
  ula_arbitro_if bus ();
  ula_arbitro_if bus_b ();
  ula_arbitro #(.PRIO_INICIAL(1'b0)) dut (.clk(clk), .reset(reset), .bus(bus));
  ula_arbitro #(.PRIO_INICIAL(1'b1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));
  always #5 clk = ~clk;
  function automatic logic [33:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    logic e;
    p = {32'b0, a} * {32'b0, b};
    r = '0;
    e = 1'b0;
    case (c)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = a + b;
      4'd3: r = a << b;
      4'd4: r = a - b;
      4'd5: r = a >> b;
      4'd6: r = p[31:0];
      4'd7: r = a ^ b;
      4'd8: r = (a < b) ? 32'd1 : 32'd0;
      default: e = 1'b1;
    endcase
    return {e, r == 32'd0, r};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mprio = 1'b0;
  endtask
  // one transaction from accept to release; during a hold, requester 0 competes and the non-owner acks
  task automatic run_op(input logic v0, input logic v1,
                        input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] b1,
                        input int hold);
    logic w;
    logic [33:0] e;
    bus.req_valid0 = v0; bus.req_ctrl0 = c0; bus.req_in1_0 = a0; bus.req_in2_0 = b0;
    bus.req_valid1 = v1; bus.req_ctrl1 = c1; bus.req_in1_1 = a1; bus.req_in2_1 = b1;
    w = (v0 && v1) ? mprio : v1;
    e = w ? ref_alu(c1, a1, b1) : ref_alu(c0, a0, b0);
    bus.resp_ready0 = (hold == 0) || w;
    bus.resp_ready1 = (hold == 0) || !w;
    #1;
    chk("req_ready0", 32'(bus.req_ready0), 32'(!w));
    chk("req_ready1", 32'(bus.req_ready1), 32'(w));
    @(posedge clk);
    mprio = !w;
    @(negedge clk);
    if (w) bus.req_valid1 = 1'b0; else bus.req_valid0 = 1'b0;
    chk("exec_resp_valid", {30'b0, bus.resp_valid1, bus.resp_valid0}, 32'd0);
    chk("exec_req_ready", {30'b0, bus.req_ready1, bus.req_ready0}, 32'd0);
    @(negedge clk);
    chk("resp_valid", {30'b0, bus.resp_valid1, bus.resp_valid0}, w ? 32'd2 : 32'd1);
    chk("resp_result", bus.resp_result, e[31:0]);
    chk("resp_zero_err", {30'b0, bus.resp_err, bus.resp_zero}, {30'b0, e[33], e[32]});
    for (int i = 0; i < hold; i++) begin
      bus.req_valid0 = 1'b1;
      @(negedge clk);
      chk("hold_valid", {30'b0, bus.resp_valid1, bus.resp_valid0}, w ? 32'd2 : 32'd1);
      chk("hold_result", {bus.resp_result[31:2], bus.resp_err, bus.resp_zero} ^ bus.resp_result, {e[31:2], e[33], e[32]} ^ e[31:0]);
      chk("hold_req_ready0", 32'(bus.req_ready0), 32'd0);
    end
    bus.resp_ready0 = 1'b1;
    bus.resp_ready1 = 1'b1;
    @(negedge clk);
    chk("released", {30'b0, bus.resp_valid1, bus.resp_valid0}, 32'd0);
  endtask
  initial begin
    {bus.req_valid0, bus.req_valid1, bus.resp_ready0, bus.resp_ready1} = '0;
    {bus.req_in1_0, bus.req_in2_0, bus.req_in1_1, bus.req_in2_1, bus.req_ctrl0, bus.req_ctrl1} = '0;
    {bus_b.req_valid0, bus_b.req_valid1, bus_b.resp_ready0, bus_b.resp_ready1} = '0;
    {bus_b.req_in1_0, bus_b.req_in2_0, bus_b.req_in1_1, bus_b.req_in2_1, bus_b.req_ctrl0, bus_b.req_ctrl1} = '0;
    do_reset();
    chk("rst_valid", {30'b0, bus.resp_valid1, bus.resp_valid0}, 32'd0);
    chk("rst_result", bus.resp_result, 32'd0);
    chk("rst_flags", {30'b0, bus.resp_err, bus.resp_zero}, 32'd0);
    chk("rst_ready", {30'b0, bus.req_ready1, bus.req_ready0}, 32'd0);
    run_op(1, 0, 4'd2, 32'd5, 32'd7, 4'd0, 32'd0, 32'd0, 0);
    do_reset();
    repeat (4) run_op(1, 1, 4'd4, 32'd9, 32'd9, 4'd7, 32'hA, 32'h5, 0);
    run_op(0, 1, 4'd0, 32'd0, 32'd0, 4'd8, 32'd3, 32'd8, 4);
    chk("req0_after_release", 32'(bus.req_ready0), 32'd1);
    run_op(1, 0, 4'b1011, 32'h1234, 32'h55, 4'd0, 32'd0, 32'd0, 0);
    run_op(1, 0, 4'd6, 32'hFFFF_FFFF, 32'd2, 4'd0, 32'd0, 32'd0, 0);
    run_op(1, 0, 4'd3, 32'd1, 32'd33, 4'd0, 32'd0, 32'd0, 0);
    run_op(1, 0, 4'd5, 32'h8000_0000, 32'd31, 4'd0, 32'd0, 32'd0, 0);
    for (int k = 0; k < 24; k++) begin
      logic r0, r1;
      logic [31:0] b0, b1;
      r0 = 1'($urandom_range(0, 1));
      r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
      b0 = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 40));
      b1 = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 40));
      run_op(r0, r1, 4'($urandom_range(0, 15)), $urandom, b0, 4'($urandom_range(0, 15)), $urandom, b1, 0);
    end
    run_op(1, 0, 4'd1, 32'hF0, 32'h0F, 4'd0, 32'd0, 32'd0, 0);
    bus.req_valid0 = 1'b1; bus.req_ctrl0 = 4'd2; bus.req_in1_0 = 32'd3; bus.req_in2_0 = 32'd4;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid0 = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mprio = 1'b0;
    chk("rst_exec_valid", {30'b0, bus.resp_valid1, bus.resp_valid0}, 32'd0);
    chk("rst_exec_result", bus.resp_result, 32'd0);
    chk("rst_exec_flags", {30'b0, bus.resp_err, bus.resp_zero}, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_no_resp", {30'b0, bus.resp_valid1, bus.resp_valid0}, 32'd0);
    bus_b.req_valid0 = 1'b1; bus_b.req_ctrl0 = 4'd2; bus_b.req_in1_0 = 32'd1; bus_b.req_in2_0 = 32'd1;
    bus_b.req_valid1 = 1'b1; bus_b.req_ctrl1 = 4'd1; bus_b.req_in1_1 = 32'hF0; bus_b.req_in2_1 = 32'h0F;
    bus_b.resp_ready0 = 1'b1; bus_b.resp_ready1 = 1'b1;
    #1;
    chk("prio1_first", {30'b0, bus_b.req_ready1, bus_b.req_ready0}, 32'd2);
    @(posedge clk);
    @(negedge clk);
    bus_b.req_valid1 = 1'b0;
    @(negedge clk);
    chk("prio1_valid", {30'b0, bus_b.resp_valid1, bus_b.resp_valid0}, 32'd2);
    chk("prio1_result", bus_b.resp_result, 32'hFF);
    @(negedge clk);
    chk("prio1_then0", {30'b0, bus_b.req_ready1, bus_b.req_ready0}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus_b.req_valid0 = 1'b0;
    @(negedge clk);
    chk("prio1_second", {30'b0, bus_b.resp_valid1, bus_b.resp_valid0}, 32'd1);
    chk("prio1_result2", bus_b.resp_result, 32'd2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
